// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command sequencer.
package alu_pkg;

   // ALU mode codes (value driven on the ALU m input)
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_CMP = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_INC = 4'h6;
   localparam logic [3:0] OP_DEC = 4'h7;
   // 4'h8..4'hF are shift/rotate modes; the low three bits select the variant
   localparam logic [3:0] OP_SHIFT_BASE = 4'h8;

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RESULT = 2'd2
   } seq_state_e;

   // Only add/sub drive a meaningful overflow; every other mode may float it
   function automatic logic ovf_mode(input logic [3:0] m);
      return (m == OP_ADD) || (m == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the external 4-bit ALU: takes a command,
// runs it cmd_rep+1 times on the accumulator, returns the final value.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DW    = 4,
   parameter int REP_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [3:0]       cmd_op,
   input  logic [DW-1:0]    cmd_data,
   input  logic [REP_W-1:0] cmd_rep,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic             alu_cin,
   output logic [3:0]       alu_m,
   input  logic [DW-1:0]    alu_r,
   input  logic             alu_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW-1:0]    res_data,
   output logic             res_ovf,
   output logic [DW-1:0]    acc
);

   seq_state_e       state_q, state_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [DW-1:0]    b_q, b_d;
   logic [3:0]       m_q, m_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [DW-1:0]    res_data_q, res_data_d;
   logic             res_ovf_q, res_ovf_d;
   logic             ovf_smp;

   // Overflow is gated by mode so a floating flag from logic/shift ops never leaks in
   assign ovf_smp = ovf_mode(m_q) & alu_ovf;

   // Next-state and datapath updates; every register holds by default
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      b_d        = b_q;
      m_d        = m_q;
      rep_d      = rep_q;
      ovf_acc_d  = ovf_acc_q;
      res_data_d = res_data_q;
      res_ovf_d  = res_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               b_d       = cmd_data;
               m_d       = cmd_op;
               rep_d     = cmd_rep;
               ovf_acc_d = 1'b0;
               if (cmd_load) begin
                  acc_d      = cmd_data;
                  res_data_d = cmd_data;
                  res_ovf_d  = 1'b0;
                  state_d    = ST_RESULT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            acc_d     = alu_r;
            ovf_acc_d = ovf_acc_q | ovf_smp;
            if (rep_q == '0) begin
               res_data_d = alu_r;
               res_ovf_d  = ovf_acc_q | ovf_smp;
               state_d    = ST_RESULT;
            end else begin
               rep_d = rep_q - REP_W'(1);
            end
         end
         ST_RESULT: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any command in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         b_q        <= '0;
         m_q        <= '0;
         rep_q      <= '0;
         ovf_acc_q  <= 1'b0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         m_q        <= m_d;
         rep_q      <= rep_d;
         ovf_acc_q  <= ovf_acc_d;
         res_data_q <= res_data_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

   // ALU operand a tracks the accumulator, so it is registered and holds outside ISSUE
   assign alu_a     = acc_q;
   assign alu_b     = b_q;
   assign alu_m     = m_q;
   assign alu_cin   = 1'b0;
   assign acc       = acc_q;
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;
   assign cmd_ready = (state_q == ST_IDLE);
   assign res_valid = (state_q == ST_RESULT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 4-bit ALU beside it and a
// result scoreboard fed by the stimulus process.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_load = 1'b0;
   logic [3:0] cmd_op = 4'h0;
   logic [3:0] cmd_data = 4'h0;
   logic [2:0] cmd_rep = 3'd0;
   logic [3:0] alu_a, alu_b, alu_m, alu_r;
   logic       alu_cin, alu_ovf;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [3:0] res_data;
   logic       res_ovf;
   logic [3:0] acc;

   typedef struct packed {
      logic [3:0] data;
      logic       ovf;
   } exp_t;
   exp_t exp_q[$];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.DW(4), .REP_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_m(alu_m),
      .alu_r(alu_r), .alu_ovf(alu_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ovf(res_ovf), .acc(acc)
   );

   // Behavioural ALU; non add/sub modes drive a junk overflow of 1
   logic [4:0] wide;
   always_comb begin
      wide    = 5'd0;
      alu_r   = alu_a;
      alu_ovf = 1'b1;
      case (alu_m)
         OP_ADD: begin
            wide    = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            alu_r   = wide[3:0];
            alu_ovf = wide[4];
         end
         OP_SUB: begin
            wide    = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
            alu_r   = wide[3:0];
            alu_ovf = wide[4];
         end
         OP_CMP:  alu_r = alu_a;
         OP_AND:  alu_r = alu_a & alu_b;
         OP_OR:   alu_r = alu_a | alu_b;
         OP_NOT:  alu_r = ~alu_a;
         OP_INC:  alu_r = alu_a + 4'd1;
         OP_DEC:  alu_r = alu_a - 4'd1;
         4'h8:    alu_r = {alu_a[2:0], 1'b0};
         4'h9:    alu_r = {1'b0, alu_a[3:1]};
         4'hC:    alu_r = {alu_a[0], alu_a[3:1]};
         4'hD:    alu_r = {alu_a[2:0], alu_a[3]};
         default: alu_r = alu_a;
      endcase
   end

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every accepted result is compared against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_result: got data=%0h with no pending command", res_data);
            end else begin
               e = exp_q.pop_front();
               check("res_data", int'(res_data), int'(e.data));
               check("res_ovf", int'(res_ovf), int'(e.ovf));
            end
         end
      end
   end

   // Drive one command through its handshake; returns #1 after the accepting edge
   task automatic send(input logic ld, input logic [3:0] op, input logic [3:0] d,
                       input logic [2:0] rep, input logic [3:0] ed, input logic eo,
                       input bit push);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_idle", int'(cmd_ready), 1);
      cmd_load  = ld;
      cmd_op    = op;
      cmd_data  = d;
      cmd_rep   = rep;
      cmd_valid = 1'b1;
      if (push) exp_q.push_back('{data: ed, ovf: eo});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Count edges from the accepting edge until res_valid shows up
   task automatic wait_res(input int exp_n);
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, exp_n);
   endtask

   task automatic run(input logic ld, input logic [3:0] op, input logic [3:0] d,
                      input logic [2:0] rep, input logic [3:0] ed, input logic eo);
      send(ld, op, d, rep, ed, eo, 1'b1);
      wait_res(ld ? 0 : int'(rep) + 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_acc", int'(acc), 0);
      check("rst_alu_a", int'(alu_a), 0);
      check("rst_alu_b", int'(alu_b), 0);
      check("rst_alu_m", int'(alu_m), 0);
      check("rst_res_data", int'(res_data), 0);
      check("rst_res_ovf", int'(res_ovf), 0);
      check("alu_cin", int'(alu_cin), 0);
      rst_n = 1'b1;

      // 1: load 5
      run(1'b1, OP_ADD, 4'h5, 3'd0, 4'h5, 1'b0);
      check("acc_after_load", int'(acc), 5);

      // 2: 5 + C = 1 with carry
      send(1'b0, OP_ADD, 4'hC, 3'd0, 4'h1, 1'b1, 1'b1);
      check("issue_alu_a", int'(alu_a), 5);
      check("issue_alu_b", int'(alu_b), 12);
      check("issue_alu_m", int'(alu_m), 0);
      wait_res(1);
      @(posedge clk);
      #1;
      check("alu_b_hold", int'(alu_b), 12);

      // 3: increment 1 five times, overflow cleared from previous command
      run(1'b0, OP_INC, 4'h0, 3'd4, 4'h6, 1'b0);

      // 4: rotate 1001 four times, then compare (junk ovf masked)
      run(1'b1, OP_ADD, 4'h9, 3'd0, 4'h9, 1'b0);
      run(1'b0, 4'hD, 4'h0, 3'd3, 4'h9, 1'b0);
      run(1'b0, OP_CMP, 4'h3, 3'd0, 4'h9, 1'b0);
      // subtract with borrow, wrap across repetitions, then a clean add
      run(1'b0, OP_SUB, 4'hA, 3'd0, 4'hF, 1'b1);
      run(1'b0, OP_ADD, 4'h1, 3'd2, 4'h2, 1'b1);
      run(1'b0, OP_ADD, 4'h0, 3'd0, 4'h2, 1'b0);
      check("acc_after_seq", int'(acc), 2);

      // 5: backpressure on the result; commands offered meanwhile are ignored
      res_ready = 1'b0;
      send(1'b1, OP_ADD, 4'h3, 3'd0, 4'h3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_res_valid", int'(res_valid), 1);
         check("hold_res_data", int'(res_data), 3);
         check("hold_cmd_ready", int'(cmd_ready), 0);
         cmd_load  = 1'b1;
         cmd_data  = 4'h7;
         cmd_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hold_cmd_ready", int'(cmd_ready), 1);
      check("post_hold_acc", int'(acc), 3);

      // 6: reset during the third ISSUE cycle of a long command
      send(1'b0, OP_INC, 4'h0, 3'd7, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_cmd_ready", int'(cmd_ready), 1);
      check("abort_res_valid", int'(res_valid), 0);
      check("abort_acc", int'(acc), 0);
      check("abort_alu_b", int'(alu_b), 0);
      check("abort_alu_m", int'(alu_m), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_idle_ready", int'(cmd_ready), 1);
      check("abort_no_result", int'(res_valid), 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
